// File: rtl/pe_column_result_drain.sv
// Drain below the bottom PE of a systolic column: drops operand beats,
// requantizes result beats and buffers them in a 2-entry skid buffer.
module pe_column_result_drain #(
    parameter int DATA_WIDTH_IN       = 16,
    parameter int FRACTIONAL_BITS_IN  = 12,
    parameter int DATA_WIDTH_OUT      = 16,
    parameter int FRACTIONAL_BITS_OUT = 12,
    parameter int USER_WIDTH          = 8,
    parameter int OP1_USER_MASK       = 1 << (USER_WIDTH - 2),
    parameter int RSLT_USER_MASK      = 1 << (USER_WIDTH - 1),
    parameter int ROW_LENGTH          = 25
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH_IN-1:0]          s_axis_down_tdata,
    input  logic                              s_axis_down_tvalid,
    output logic                              s_axis_down_tready,
    input  logic                              s_axis_down_tlast,
    input  logic [USER_WIDTH-1:0]             s_axis_down_tuser,
    output logic [DATA_WIDTH_OUT-1:0]         m_axis_rslt_tdata,
    output logic                              m_axis_rslt_tvalid,
    input  logic                              m_axis_rslt_tready,
    output logic                              m_axis_rslt_tlast,
    output logic [$clog2(ROW_LENGTH+1)-1:0]   result_count,
    output logic                              err_length,
    output logic                              err_user_flag
);

    localparam int CW  = $clog2(ROW_LENGTH + 1);
    localparam int SH  = FRACTIONAL_BITS_IN - FRACTIONAL_BITS_OUT;
    localparam int SHA = (SH < 0) ? -SH : SH;
    localparam int IW0 = DATA_WIDTH_IN + SHA + 2;
    localparam int IW  = (IW0 > DATA_WIDTH_OUT + 1) ? IW0 : DATA_WIDTH_OUT + 1;

    localparam logic signed [IW-1:0] MAXV =
        {{(IW - DATA_WIDTH_OUT + 1){1'b0}}, {(DATA_WIDTH_OUT - 1){1'b1}}};
    localparam logic signed [IW-1:0] MINV =
        {{(IW - DATA_WIDTH_OUT + 1){1'b1}}, {(DATA_WIDTH_OUT - 1){1'b0}}};

    logic                      beat_rslt;
    logic                      beat_op1;
    logic                      accept;
    logic                      push;
    logic                      bad_user;
    logic                      pop;
    logic signed [IW-1:0]      ext;
    logic signed [IW-1:0]      scaled;
    logic [DATA_WIDTH_OUT-1:0] q_data;
    logic [CW:0]               cnt_inc;
    logic                      cnt_hit;
    logic                      q_last;

    logic                      sp_valid;
    logic [DATA_WIDTH_OUT-1:0] sp_data;
    logic                      sp_last;

    assign beat_rslt = |(s_axis_down_tuser & USER_WIDTH'(RSLT_USER_MASK));
    assign beat_op1  = |(s_axis_down_tuser & USER_WIDTH'(OP1_USER_MASK));

    // Ready only reflects the spare slot, so the output side never
    // reaches back to the upstream PE in the same cycle.
    assign s_axis_down_tready = !sp_valid && !rst;

    assign accept   = s_axis_down_tvalid && s_axis_down_tready;
    assign push     = accept && beat_rslt && !beat_op1;
    assign bad_user = accept && (beat_rslt == beat_op1);
    assign pop      = m_axis_rslt_tvalid && m_axis_rslt_tready;

    assign ext = {{(IW - DATA_WIDTH_IN){s_axis_down_tdata[DATA_WIDTH_IN-1]}},
                  s_axis_down_tdata};

    generate
        if (SH > 0) begin : g_down
            localparam logic signed [IW-1:0] RND = IW'(1) << (SH - 1);
            assign scaled = (ext + RND) >>> SH;
        end else if (SH < 0) begin : g_up
            assign scaled = ext <<< SHA;
        end else begin : g_pass
            assign scaled = ext;
        end
    endgenerate

    // Clamp the rescaled value into the signed output range.
    always_comb begin
        q_data = scaled[DATA_WIDTH_OUT-1:0];
        if (scaled > MAXV) begin
            q_data = MAXV[DATA_WIDTH_OUT-1:0];
        end else if (scaled < MINV) begin
            q_data = MINV[DATA_WIDTH_OUT-1:0];
        end
    end

    assign cnt_inc = {1'b0, result_count} + 1'b1;
    assign cnt_hit = (cnt_inc == (CW + 1)'(ROW_LENGTH));
    assign q_last  = s_axis_down_tlast || cnt_hit;

    // Packet counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_count  <= '0;
            err_length    <= 1'b0;
            err_user_flag <= 1'b0;
        end else begin
            if (push) begin
                if (q_last) begin
                    result_count <= '0;
                end else begin
                    result_count <= cnt_inc[CW-1:0];
                end
                if (s_axis_down_tlast != cnt_hit) begin
                    err_length <= 1'b1;
                end
            end
            if (bad_user) begin
                err_user_flag <= 1'b1;
            end
        end
    end

    // Skid buffer: output register refills from the spare first, then
    // from the incoming beat; the spare only fills while output stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_rslt_tvalid <= 1'b0;
            m_axis_rslt_tdata  <= '0;
            m_axis_rslt_tlast  <= 1'b0;
            sp_valid           <= 1'b0;
            sp_data            <= '0;
            sp_last            <= 1'b0;
        end else if (!m_axis_rslt_tvalid || pop) begin
            if (sp_valid) begin
                m_axis_rslt_tvalid <= 1'b1;
                m_axis_rslt_tdata  <= sp_data;
                m_axis_rslt_tlast  <= sp_last;
                sp_valid           <= push;
                if (push) begin
                    sp_data <= q_data;
                    sp_last <= q_last;
                end
            end else begin
                m_axis_rslt_tvalid <= push;
                if (push) begin
                    m_axis_rslt_tdata <= q_data;
                    m_axis_rslt_tlast <= q_last;
                end
            end
        end else if (push) begin
            sp_valid <= 1'b1;
            sp_data  <= q_data;
            sp_last  <= q_last;
        end
    end

endmodule

// File: tb/tb_pe_column_result_drain.sv
// Scoreboard bench: three drain instances (12, 8 and 14 output fraction
// bits) with directed stimulus and a negedge monitor.
module tb_pe_column_result_drain;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_data  [3];
    logic        s_valid [3];
    logic        s_ready [3];
    logic        s_last  [3];
    logic [7:0]  s_user  [3];
    logic [15:0] m_data  [3];
    logic        m_valid [3];
    logic        m_ready [3];
    logic        m_last  [3];
    logic [4:0]  cnt     [3];
    logic        errl    [3];
    logic        erru    [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_chk  = 0;
    int n_pass = 0;

    logic        prev_stall = 1'b0;
    logic [15:0] prev_d;
    logic        prev_l;

    always #5 clk = ~clk;

    pe_column_result_drain u_a (
        .clk(clk), .rst(rst),
        .s_axis_down_tdata(s_data[0]), .s_axis_down_tvalid(s_valid[0]),
        .s_axis_down_tready(s_ready[0]), .s_axis_down_tlast(s_last[0]),
        .s_axis_down_tuser(s_user[0]),
        .m_axis_rslt_tdata(m_data[0]), .m_axis_rslt_tvalid(m_valid[0]),
        .m_axis_rslt_tready(m_ready[0]), .m_axis_rslt_tlast(m_last[0]),
        .result_count(cnt[0]), .err_length(errl[0]), .err_user_flag(erru[0])
    );

    pe_column_result_drain #(.FRACTIONAL_BITS_OUT(8)) u_b (
        .clk(clk), .rst(rst),
        .s_axis_down_tdata(s_data[1]), .s_axis_down_tvalid(s_valid[1]),
        .s_axis_down_tready(s_ready[1]), .s_axis_down_tlast(s_last[1]),
        .s_axis_down_tuser(s_user[1]),
        .m_axis_rslt_tdata(m_data[1]), .m_axis_rslt_tvalid(m_valid[1]),
        .m_axis_rslt_tready(m_ready[1]), .m_axis_rslt_tlast(m_last[1]),
        .result_count(cnt[1]), .err_length(errl[1]), .err_user_flag(erru[1])
    );

    pe_column_result_drain #(.FRACTIONAL_BITS_OUT(14)) u_c (
        .clk(clk), .rst(rst),
        .s_axis_down_tdata(s_data[2]), .s_axis_down_tvalid(s_valid[2]),
        .s_axis_down_tready(s_ready[2]), .s_axis_down_tlast(s_last[2]),
        .s_axis_down_tuser(s_user[2]),
        .m_axis_rslt_tdata(m_data[2]), .m_axis_rslt_tvalid(m_valid[2]),
        .m_axis_rslt_tready(m_ready[2]), .m_axis_rslt_tlast(m_last[2]),
        .result_count(cnt[2]), .err_length(errl[2]), .err_user_flag(erru[2])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic send(input int k, input logic [15:0] d,
                        input logic [7:0] u, input logic l,
                        input logic [15:0] ed, input logic el);
        exp_t e;
        int   t;
        logic acc;
        e.d = ed;
        e.l = el;
        if (u == 8'h80) begin
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        s_data[k]  = d;
        s_user[k]  = u;
        s_last[k]  = l;
        s_valid[k] = 1'b1;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = s_ready[k];
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            n_chk++;
            $display("FAIL send_timeout: dut %0d beat %0h not accepted", k, d);
        end
        s_valid[k] = 1'b0;
    endtask

    // Monitor: pop expected on every output handshake, check stall hold.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (m_valid[k] && m_ready[k]) begin
                if ((k == 0 && q0.size() == 0) ||
                    (k == 1 && q1.size() == 0) ||
                    (k == 2 && q2.size() == 0)) begin
                    n_chk++;
                    $display("FAIL unexpected_out: dut %0d data %0h", k, m_data[k]);
                end else begin
                    case (k)
                        0:       e = q0.pop_front();
                        1:       e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    chk($sformatf("data_dut%0d", k), 32'(m_data[k]), 32'(e.d));
                    chk($sformatf("last_dut%0d", k), 32'(m_last[k]), 32'(e.l));
                end
            end
        end
        if (prev_stall && m_valid[0]) begin
            chk("hold_data", 32'(m_data[0]), 32'(prev_d));
            chk("hold_last", 32'(m_last[0]), 32'(prev_l));
        end
        prev_stall = m_valid[0] && !m_ready[0];
        prev_d     = m_data[0];
        prev_l     = m_last[0];
    end

    initial begin
        logic [15:0] vals [5];
        int t;
        vals[0] = 16'hC000;
        vals[1] = 16'hF000;
        vals[2] = 16'h0000;
        vals[3] = 16'h1000;
        vals[4] = 16'h4000;
        for (int k = 0; k < 3; k++) begin
            s_data[k]  = '0;
            s_valid[k] = 1'b0;
            s_last[k]  = 1'b0;
            s_user[k]  = '0;
            m_ready[k] = 1'b1;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(m_valid[0]), 32'd0);
        chk("rst_tdata", 32'(m_data[0]), 32'd0);
        chk("rst_count", 32'(cnt[0]), 32'd0);
        chk("rst_errl", 32'(errl[0]), 32'd0);
        chk("rst_erru", 32'(erru[0]), 32'd0);
        chk("rst_tready", 32'(s_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("tready_after_rst", 32'(s_ready[0]), 32'd1);

        send(0, vals[0], 8'h80, 1'b0, vals[0], 1'b0);
        chk("latency_1cyc", 32'(m_valid[0]), 32'd1);
        for (int i = 1; i < 25; i++) begin
            send(0, vals[i % 5], 8'h80, i == 24, vals[i % 5], i == 24);
        end
        chk("t1_errl", 32'(errl[0]), 32'd0);
        chk("t1_erru", 32'(erru[0]), 32'd0);
        chk("t1_count", 32'(cnt[0]), 32'd0);

        for (int i = 0; i < 25; i++) begin
            send(0, 16'h0123, 8'h40, i == 24, 16'h0, 1'b0);
            send(0, vals[i % 5], 8'h80, i == 24, vals[i % 5], i == 24);
        end
        chk("t2_errl", 32'(errl[0]), 32'd0);
        chk("t2_erru", 32'(erru[0]), 32'd0);

        send(1, 16'h1000, 8'h80, 1'b0, 16'd256, 1'b0);
        send(1, 16'd24, 8'h80, 1'b0, 16'd2, 1'b0);
        send(1, 16'hFFE8, 8'h80, 1'b0, 16'hFFFF, 1'b0);
        send(1, 16'h7FF8, 8'h80, 1'b0, 16'd2048, 1'b0);
        send(2, 16'h4000, 8'h80, 1'b0, 16'h7FFF, 1'b0);
        send(2, 16'hC000, 8'h80, 1'b0, 16'h8000, 1'b0);
        send(2, 16'h1000, 8'h80, 1'b0, 16'h4000, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        m_ready[0] = 1'b0;
        fork
            begin
                send(0, 16'h0011, 8'h80, 1'b0, 16'h0011, 1'b0);
                send(0, 16'h0022, 8'h80, 1'b0, 16'h0022, 1'b0);
                send(0, 16'h0033, 8'h80, 1'b0, 16'h0033, 1'b0);
                send(0, 16'h0044, 8'h80, 1'b0, 16'h0044, 1'b0);
            end
            begin
                repeat (6) @(negedge clk);
                chk("stall_tready", 32'(s_ready[0]), 32'd0);
                chk("stall_count", 32'(cnt[0]), 32'd2);
                @(posedge clk);
                #1;
                m_ready[0] = 1'b1;
            end
        join
        for (int i = 4; i < 25; i++) begin
            send(0, vals[i % 5], 8'h80, i == 24, vals[i % 5], i == 24);
        end
        chk("t5_errl", 32'(errl[0]), 32'd0);

        for (int i = 0; i < 10; i++) begin
            send(0, vals[i % 5], 8'h80, i == 9, vals[i % 5], i == 9);
        end
        chk("short_errl", 32'(errl[0]), 32'd1);
        chk("short_count", 32'(cnt[0]), 32'd0);

        send(0, 16'h1234, 8'hC0, 1'b0, 16'h0, 1'b0);
        chk("bad_user_erru", 32'(erru[0]), 32'd1);
        chk("bad_user_count", 32'(cnt[0]), 32'd0);

        for (int i = 0; i < 3; i++) begin
            send(0, vals[i], 8'h80, 1'b0, vals[i], 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        m_ready[0] = 1'b0;
        send(0, 16'h0055, 8'h80, 1'b0, 16'h0055, 1'b0);
        send(0, 16'h0066, 8'h80, 1'b0, 16'h0066, 1'b0);
        chk("pre_rst_count", 32'(cnt[0]), 32'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q0.delete();
        chk("midrst_tvalid", 32'(m_valid[0]), 32'd0);
        chk("midrst_count", 32'(cnt[0]), 32'd0);
        chk("midrst_errl", 32'(errl[0]), 32'd0);
        chk("midrst_erru", 32'(erru[0]), 32'd0);
        chk("midrst_tready", 32'(s_ready[0]), 32'd0);
        rst = 1'b0;
        m_ready[0] = 1'b1;
        #1;
        chk("midrst_tready_after", 32'(s_ready[0]), 32'd1);
        send(0, 16'h0077, 8'h80, 1'b0, 16'h0077, 1'b0);
        chk("new_pkt_count", 32'(cnt[0]), 32'd1);

        t = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expected beats never emitted",
                     q0.size() + q1.size() + q2.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
